// File: rtl/rv_div_unit_pkg.sv
// Shared constants, op codes, state encoding and op-class helpers for the RV32M divider.
package rv_div_unit_pkg;

   localparam int unsigned XLEN_DEF = 32;

   // ALU_ContUnit op codes for the divide class
   localparam logic [4:0] ALU_DIV  = 5'b01100;
   localparam logic [4:0] ALU_DIVU = 5'b01101;
   localparam logic [4:0] ALU_REM  = 5'b01110;
   localparam logic [4:0] ALU_REMU = 5'b01111;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2
   } div_state_e;

   function automatic logic is_div_op(input logic [4:0] sel);
      return (sel == ALU_DIV) || (sel == ALU_DIVU) || (sel == ALU_REM) || (sel == ALU_REMU);
   endfunction

   function automatic logic is_signed_op(input logic [4:0] sel);
      return (sel == ALU_DIV) || (sel == ALU_REM);
   endfunction

   function automatic logic is_rem_op(input logic [4:0] sel);
      return (sel == ALU_REM) || (sel == ALU_REMU);
   endfunction

endpackage

// File: rtl/rv_div_unit_if.sv
// Request/response bundle between the EX stage and the divider.
interface rv_div_unit_if #(
   parameter int unsigned XLEN = rv_div_unit_pkg::XLEN_DEF
);
   logic            start;
   logic [4:0]      ALU_sel;
   logic            flush;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, ALU_sel, flush, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, ALU_sel, flush, a, b,
      output busy, done, result
   );
endinterface

// File: rtl/rv_div_unit_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module rv_div_unit_div_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN:0]   rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN:0]   rem_next,
   output logic [XLEN-1:0] quo_next
);
   logic [XLEN:0] shifted;
   logic [XLEN:0] trial;
   logic          unused_rem_msb;

   // The partial remainder is always below the divisor, so its top bit never carries data in.
   assign unused_rem_msb = rem[XLEN];

   assign shifted  = {rem[XLEN-1:0], quo[XLEN-1]};
   assign trial    = shifted - {1'b0, divisor};
   assign rem_next = trial[XLEN] ? shifted : trial;
   assign quo_next = {quo[XLEN-2:0], ~trial[XLEN]};
endmodule

// File: rtl/rv_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with RISC-V corner-case results.
module rv_div_unit
   import rv_div_unit_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input logic          clk,
   input logic          rst,
   rv_div_unit_if.slave bus
);
   localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

   div_state_e       state;
   logic [CNT_W-1:0] counter;
   logic [XLEN:0]    rem_q;
   logic [XLEN-1:0]  quo_q;
   logic [XLEN-1:0]  dvsr_q;
   logic             rem_op_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic             busy_q;
   logic             done_q;
   logic [XLEN-1:0]  result_q;

   logic             signed_op;
   logic             rem_op;
   logic             sign_a;
   logic             sign_b;
   logic [XLEN-1:0]  abs_a;
   logic [XLEN-1:0]  abs_b;
   logic             div_zero;
   logic             overflow;
   logic [XLEN-1:0]  special_res;
   logic [XLEN-1:0]  fix_res;
   logic [XLEN:0]    rem_next;
   logic [XLEN-1:0]  quo_next;
   logic             accept;

   // Operand decode, magnitudes and corner-case detection for the accept cycle
   always_comb begin
      signed_op   = is_signed_op(bus.ALU_sel);
      rem_op      = is_rem_op(bus.ALU_sel);
      sign_a      = signed_op & bus.a[XLEN-1];
      sign_b      = signed_op & bus.b[XLEN-1];
      abs_a       = sign_a ? (~bus.a + XLEN'(1)) : bus.a;
      abs_b       = sign_b ? (~bus.b + XLEN'(1)) : bus.b;
      div_zero    = (bus.b == '0);
      overflow    = signed_op && (bus.a == INT_MIN) && (bus.b == ALL_ONES);
      special_res = '0;
      if (div_zero) begin
         special_res = rem_op ? bus.a : ALL_ONES;
      end else if (overflow) begin
         special_res = rem_op ? '0 : INT_MIN;
      end
      accept = !bus.flush && bus.start && is_div_op(bus.ALU_sel);
   end

   // Sign correction and quotient/remainder select for the FIX cycle
   always_comb begin
      fix_res = '0;
      if (rem_op_q) begin
         fix_res = neg_rem_q ? (~rem_q[XLEN-1:0] + XLEN'(1)) : rem_q[XLEN-1:0];
      end else begin
         fix_res = neg_quo_q ? (~quo_q + XLEN'(1)) : quo_q;
      end
   end

   rv_div_unit_div_step #(.XLEN(XLEN)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvsr_q),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   // Control FSM, iteration datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= DIV_IDLE;
         counter   <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         rem_op_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            DIV_IDLE: begin
               if (accept) begin
                  if (div_zero || overflow) begin
                     result_q <= special_res;
                     done_q   <= 1'b1;
                  end else begin
                     state     <= DIV_CALC;
                     busy_q    <= 1'b1;
                     counter   <= '0;
                     rem_q     <= '0;
                     quo_q     <= abs_a;
                     dvsr_q    <= abs_b;
                     rem_op_q  <= rem_op;
                     neg_quo_q <= sign_a ^ sign_b;
                     neg_rem_q <= sign_a;
                  end
               end
            end
            DIV_CALC: begin
               if (bus.flush) begin
                  state  <= DIV_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  rem_q <= rem_next;
                  quo_q <= quo_next;
                  if (counter == CNT_W'(XLEN-1)) begin
                     state <= DIV_FIX;
                  end else begin
                     counter <= counter + CNT_W'(1);
                  end
               end
            end
            DIV_FIX: begin
               state  <= DIV_IDLE;
               busy_q <= 1'b0;
               if (!bus.flush) begin
                  result_q <= fix_res;
                  done_q   <= 1'b1;
               end
            end
            default: begin
               state  <= DIV_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule
